// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the ALU execute stage: datapath widths and the 4-bit ALU opcode map.
package alu_exec_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1101;
    localparam logic [3:0] OP_NOR  = 4'b1110;
    localparam logic [3:0] OP_HAM  = 4'b1111;

endpackage

// File: rtl/alu_exec_stage_alu_fwd_mux.sv
// Per-operand source select: immediate, hardwired r0, EX-stage forward, WB-stage forward, then
// register-file read data, in that priority order.
module alu_fwd_mux
    import alu_exec_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] src_reg,
    input  logic               use_imm,
    input  logic [XLEN-1:0]    imm,
    input  logic               ex_valid,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic [XLEN-1:0]    rf_data,
    output logic [XLEN-1:0]    operand
);

    logic ex_hit_s;
    logic wb_hit_s;

    // A pending write to r0 must never be forwarded, hence the nonzero-destination qualifier.
    assign ex_hit_s = ex_valid && (ex_rd == src_reg) && (ex_rd != {RADDR_W{1'b0}});
    assign wb_hit_s = wb_valid && (wb_rd == src_reg) && (wb_rd != {RADDR_W{1'b0}});

    // Operand priority select; the youngest in-flight producer wins.
    always_comb begin
        operand = {XLEN{1'b0}};
        if (use_imm) begin
            operand = imm;
        end else if (src_reg == {RADDR_W{1'b0}}) begin
            operand = {XLEN{1'b0}};
        end else if (ex_hit_s) begin
            operand = ex_data;
        end else if (wb_hit_s) begin
            operand = wb_data;
        end else begin
            operand = rf_data;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: operand select with forwarding into the EX register that feeds an external ALU,
// then a WB register handed to register-file writeback, with full-throughput backpressure.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [RADDR_W-1:0] in_rs,
    input  logic [RADDR_W-1:0] in_rt,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_use_imm,
    input  logic [XLEN-1:0]    in_imm,
    output logic [RADDR_W-1:0] rf_raddr1,
    output logic [RADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [3:0]         alu_op,
    input  logic [XLEN-1:0]    alu_result,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic [31:0]        retire_cnt
);

    logic               ex_valid_r;
    logic [RADDR_W-1:0] ex_rd_r;
    logic               wb_adv_s;
    logic               ex_adv_s;
    logic               accept_s;
    logic               retire_s;
    logic [XLEN-1:0]    a_sel_s;
    logic [XLEN-1:0]    b_sel_s;

    // EX may refill whenever its current op moves on (or it is empty), which gives one op per cycle.
    assign wb_adv_s  = !wb_valid || wb_ready;
    assign ex_adv_s  = !ex_valid_r || wb_adv_s;
    assign accept_s  = in_valid && ex_adv_s;
    assign retire_s  = wb_valid && wb_ready;
    assign in_ready  = ex_adv_s;
    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

    alu_fwd_mux u_fwd_a (
        .src_reg  (in_rs),
        .use_imm  (1'b0),
        .imm      ({XLEN{1'b0}}),
        .ex_valid (ex_valid_r),
        .ex_rd    (ex_rd_r),
        .ex_data  (alu_result),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_data  (rf_rdata1),
        .operand  (a_sel_s)
    );

    alu_fwd_mux u_fwd_b (
        .src_reg  (in_rt),
        .use_imm  (in_use_imm),
        .imm      (in_imm),
        .ex_valid (ex_valid_r),
        .ex_rd    (ex_rd_r),
        .ex_data  (alu_result),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_data  (rf_rdata2),
        .operand  (b_sel_s)
    );

    // EX register: captures the accepted op and its selected operands; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_rd_r    <= {RADDR_W{1'b0}};
            alu_a      <= {XLEN{1'b0}};
            alu_b      <= {XLEN{1'b0}};
            alu_op     <= OP_ADD;
        end else if (accept_s) begin
            ex_valid_r <= 1'b1;
            ex_rd_r    <= in_rd;
            alu_a      <= a_sel_s;
            alu_b      <= b_sel_s;
            alu_op     <= in_opcode;
        end else if (ex_adv_s) begin
            ex_valid_r <= 1'b0;
        end
    end

    // WB register: captures the ALU result of the EX op when the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= {RADDR_W{1'b0}};
            wb_data  <= {XLEN{1'b0}};
        end else if (wb_adv_s) begin
            wb_valid <= ex_valid_r;
            if (ex_valid_r) begin
                wb_rd   <= ex_rd_r;
                wb_data <= alu_result;
            end
        end
    end

    // Retire counter: one count per writeback handshake, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= 32'd0;
        end else if (retire_s) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule
